// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_seq_state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 1048576;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_RETRY_MAX     = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Reusable two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings the PLL from power-up to a qualified lock, retrying on timeout, and
// holds the downstream core in reset until the lock has been stable.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int RETRY_MAX     = DEF_RETRY_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked_in,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);

    localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

    localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIM   = 4'(RETRY_MAX);

    pll_seq_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic             lost_q, lost_d;
    logic             pll_rst_q, pll_rst_d;
    logic             run_q, run_d;
    logic             fail_q, fail_d;
    logic             lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked_in),
        .q     (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = lost_q;

        unique case (state_q)
            PLL_RESET: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = LOCK_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = STABLE_LOAD;
                end else if (cnt_q == '0) begin
                    // Saturate so the count can never wrap past the limit.
                    retry_d = (retry_q >= RETRY_LIM) ? RETRY_LIM : retry_q + 4'd1;
                    state_d = (retry_d == RETRY_LIM) ? FAIL : PLL_RESET;
                    cnt_d   = RST_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = LOCK_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RESET;
                    cnt_d   = RST_LOAD;
                    retry_d = 4'd0;
                    lost_d  = 1'b1;
                end
            end
            FAIL: begin
            end
            default: begin
                state_d = PLL_RESET;
                cnt_d   = RST_LOAD;
            end
        endcase

        // Software relock overrides whatever the state logic decided.
        if (relock_req) begin
            state_d = PLL_RESET;
            cnt_d   = RST_LOAD;
            retry_d = 4'd0;
            lost_d  = 1'b0;
        end

        pll_rst_d = (state_d == PLL_RESET);
        run_d     = (state_d == RUN);
        fail_d    = (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLL_RESET;
            cnt_q     <= RST_LOAD;
            retry_q   <= 4'd0;
            lost_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            run_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst_q <= pll_rst_d;
            run_q     <= run_d;
            fail_q    <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = run_q;
    assign ready     = run_q;
    assign fail      = fail_q;
    assign lock_lost = lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked_in;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .RETRY_MAX     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked_in  (locked_in),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advance_to(input int k);
        while (cyc < k) tick();
    endtask

    // Cycle 0 is the interval between reset release and the first edge.
    task automatic do_reset();
        rst_n      = 1'b0;
        locked_in  = 1'b0;
        relock_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (pll_rst !== 1'b1)   begin errors++; $display("FAIL reset_pll_rst got %0b exp 1", pll_rst); end
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL reset_sys_rst_n got %0b exp 0", sys_rst_n); end
        checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready got %0b exp 0", ready); end
        checks++; if (fail !== 1'b0)      begin errors++; $display("FAIL reset_fail got %0b exp 0", fail); end
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lock_lost got %0b exp 0", lock_lost); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry got %0d exp 0", retry_cnt); end
    endtask

    task automatic test_basic_lock();
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            advance_to(c);
            checks++;
            if (pll_rst !== (c < 4)) begin
                errors++; $display("FAIL t1_pll_rst_c%0d got %0b exp %0b", c, pll_rst, (c < 4));
            end
        end
        advance_to(10);
        locked_in = 1'b1;
        advance_to(20);
        checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL t1_ready_c20 got %0b exp 0", ready); end
        checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL t1_sys_rst_n_c20 got %0b exp 0", sys_rst_n); end
        advance_to(21);
        checks++; if (ready !== 1'b1)     begin errors++; $display("FAIL t1_ready_c21 got %0b exp 1", ready); end
        checks++; if (sys_rst_n !== 1'b1) begin errors++; $display("FAIL t1_sys_rst_n_c21 got %0b exp 1", sys_rst_n); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL t1_retry got %0d exp 0", retry_cnt); end
        checks++; if (pll_rst !== 1'b0)   begin errors++; $display("FAIL t1_pll_rst_c21 got %0b exp 0", pll_rst); end
    endtask

    task automatic test_retry_fail();
        do_reset();
        advance_to(35);
        checks++; if (pll_rst !== 1'b0 || retry_cnt !== 4'd0) begin
            errors++; $display("FAIL t2_c35 got pll_rst=%0b retry=%0d exp 0/0", pll_rst, retry_cnt); end
        advance_to(36);
        checks++; if (pll_rst !== 1'b1 || retry_cnt !== 4'd1) begin
            errors++; $display("FAIL t2_c36 got pll_rst=%0b retry=%0d exp 1/1", pll_rst, retry_cnt); end
        advance_to(39);
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL t2_pll_rst_c39 got %0b exp 1", pll_rst); end
        advance_to(40);
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL t2_pll_rst_c40 got %0b exp 0", pll_rst); end
        advance_to(71);
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL t2_fail_c71 got %0b exp 0", fail); end
        advance_to(72);
        checks++; if (fail !== 1'b1 || retry_cnt !== 4'd2 || pll_rst !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL t2_c72 got fail=%0b retry=%0d pll_rst=%0b ready=%0b exp 1/2/0/0",
                               fail, retry_cnt, pll_rst, ready); end
        advance_to(80);
        checks++; if (fail !== 1'b1 || retry_cnt !== 4'd2) begin
            errors++; $display("FAIL t2_hold_c80 got fail=%0b retry=%0d exp 1/2", fail, retry_cnt); end
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++; if (pll_rst !== 1'b1 || retry_cnt !== 4'd0 || fail !== 1'b0) begin
            errors++; $display("FAIL t2_relock got pll_rst=%0b retry=%0d fail=%0b exp 1/0/0",
                               pll_rst, retry_cnt, fail); end
    endtask

    task automatic test_stable_glitch();
        int bad_rst;
        bad_rst = 0;
        do_reset();
        advance_to(10);
        locked_in = 1'b1;
        advance_to(15);
        locked_in = 1'b0;
        advance_to(16);
        locked_in = 1'b1;
        for (int c = 17; c <= 27; c++) begin
            advance_to(c);
            if (pll_rst !== 1'b0) bad_rst++;
        end
        checks++; if (bad_rst != 0) begin errors++; $display("FAIL t3_no_pll_rst got %0d high cycles exp 0", bad_rst); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL t3_ready_c27 got %0b exp 1", ready); end
        checks++; if (retry_cnt !== 4'd0) begin errors++; $display("FAIL t3_retry got %0d exp 0", retry_cnt); end
        do_reset();
        advance_to(10);
        locked_in = 1'b1;
        advance_to(15);
        locked_in = 1'b0;
        advance_to(16);
        locked_in = 1'b1;
        advance_to(21);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL t3_ready_c21 got %0b exp 0", ready); end
        advance_to(26);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL t3_ready_c26 got %0b exp 0", ready); end
    endtask

    task automatic test_lock_loss();
        do_reset();
        advance_to(10);
        locked_in = 1'b1;
        advance_to(25);
        locked_in = 1'b0;
        advance_to(27);
        checks++; if (ready !== 1'b1 || pll_rst !== 1'b0) begin
            errors++; $display("FAIL t4_c27 got ready=%0b pll_rst=%0b exp 1/0", ready, pll_rst); end
        advance_to(28);
        checks++; if (ready !== 1'b0 || sys_rst_n !== 1'b0 || lock_lost !== 1'b1 || pll_rst !== 1'b1) begin
            errors++; $display("FAIL t4_c28 got ready=%0b sys_rst_n=%0b lock_lost=%0b pll_rst=%0b exp 0/0/1/1",
                               ready, sys_rst_n, lock_lost, pll_rst); end
        advance_to(31);
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL t4_pll_rst_c31 got %0b exp 1", pll_rst); end
        advance_to(32);
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL t4_pll_rst_c32 got %0b exp 0", pll_rst); end
        advance_to(35);
        locked_in = 1'b1;
        advance_to(45);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL t4_ready_c45 got %0b exp 0", ready); end
        advance_to(46);
        checks++; if (ready !== 1'b1 || lock_lost !== 1'b1 || retry_cnt !== 4'd0) begin
            errors++; $display("FAIL t4_rerun_c46 got ready=%0b lock_lost=%0b retry=%0d exp 1/1/0",
                               ready, lock_lost, retry_cnt); end
    endtask

    task automatic test_relock_at_timeout();
        do_reset();
        advance_to(10);
        locked_in = 1'b1;
        advance_to(25);
        locked_in = 1'b0;
        advance_to(62);
        checks++; if (lock_lost !== 1'b1 || pll_rst !== 1'b0) begin
            errors++; $display("FAIL t5_c62 got lock_lost=%0b pll_rst=%0b exp 1/0", lock_lost, pll_rst); end
        advance_to(63);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++; if (pll_rst !== 1'b1 || retry_cnt !== 4'd0 || lock_lost !== 1'b0 || fail !== 1'b0) begin
            errors++; $display("FAIL t5_c64 got pll_rst=%0b retry=%0d lock_lost=%0b fail=%0b exp 1/0/0/0",
                               pll_rst, retry_cnt, lock_lost, fail); end
        advance_to(67);
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL t5_pll_rst_c67 got %0b exp 1", pll_rst); end
        advance_to(68);
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL t5_pll_rst_c68 got %0b exp 0", pll_rst); end
    endtask

    task automatic test_async_reset();
        do_reset();
        advance_to(40);
        locked_in = 1'b1;
        advance_to(45);
        checks++; if (retry_cnt !== 4'd1 || pll_rst !== 1'b0) begin
            errors++; $display("FAIL t6_c45 got retry=%0d pll_rst=%0b exp 1/0", retry_cnt, pll_rst); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0 ||
                      fail !== 1'b0 || lock_lost !== 1'b0 || retry_cnt !== 4'd0) begin
            errors++; $display("FAIL t6_async got pll_rst=%0b sys_rst_n=%0b ready=%0b fail=%0b lost=%0b retry=%0d exp 1/0/0/0/0/0",
                               pll_rst, sys_rst_n, ready, fail, lock_lost, retry_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        locked_in  = 1'b0;
        relock_req = 1'b0;
        test_reset();
        test_basic_lock();
        test_retry_fail();
        test_stable_glitch();
        test_lock_loss();
        test_relock_at_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences the system PLL (50 MHz reference, 4.000000 MHz and 4.194528 MHz outputs) from power-up to a stable, locked state. Drives the PLL reset, synchronizes and qualifies its `locked` output, and retries on lock timeout. Holds the downstream core reset until lock has been continuously stable, and handles lock loss and software relock requests. Runs on the 50 MHz reference clock, beside the PLL instance in the top level.

## Interface
- `RST_CYCLES`, default 16: cycles PLL reset is held high per attempt (≥2).
- `LOCK_TIMEOUT`, default 1048576: cycles to wait for lock before retrying (≥2).
- `STABLE_CYCLES`, default 1024: consecutive synced-lock cycles required before release (≥2).
- `RETRY_MAX`, default 7: failed attempts before entering FAIL (1..15).
- `clk` in 1: 50 MHz reference clock, the same net as the PLL `refclk`.
- `rst_n` in 1: reset, asynchronous, active-low.
- `locked_in` in 1: PLL `locked`; asynchronous to `clk`.
- `relock_req` in 1: single-cycle request to restart the full sequence.
- `pll_rst` out 1: to the PLL `rst` port; active high.
- `sys_rst_n` out 1: downstream core reset; active low.
- `ready` out 1: high only in RUN.
- `fail` out 1: high only in FAIL.
- `lock_lost` out 1: sticky flag; set on lock loss in RUN; cleared only by `rst_n` or `relock_req`.
- `retry_cnt` out 4: failed attempts in the current sequence.

## Operation
- `locked_in` passes through a 2-flop synchronizer to give `lock_s`. All decisions use `lock_s`.
- One down-counter `cnt` is shared by all states. Its width is `$clog2` of the maximum of the three cycle parameters.
- States: PLL_RESET, WAIT_LOCK, STABLE, RUN, FAIL.
- **PLL_RESET**
  - `pll_rst`=1; `cnt` loaded with RST_CYCLES-1.
  - At `cnt`==0, go to WAIT_LOCK and load `cnt` with LOCK_TIMEOUT-1.
- **WAIT_LOCK**
  - `pll_rst`=0.
  - If `lock_s`=1, go to STABLE and load `cnt` with STABLE_CYCLES-1.
  - Else if `cnt`==0, increment `retry_cnt`. If the new value equals RETRY_MAX, go to FAIL; otherwise go to PLL_RESET.
- **STABLE**
  - If `lock_s`=0, go to WAIT_LOCK and reload the timeout. `retry_cnt` is unchanged.
  - Else if `cnt`==0, go to RUN.
- **RUN**
  - `sys_rst_n`=1, `ready`=1.
  - If `lock_s`=0: set `lock_lost`, clear `retry_cnt`, go to PLL_RESET.
- **FAIL**
  - `pll_rst`=0, `fail`=1. Waits for `relock_req`.
- **relock_req** in any state has priority over every other transition in the same cycle. It goes to PLL_RESET and clears `retry_cnt` and `lock_lost`.
- `sys_rst_n`=0 in every state except RUN.

## Timing
- All outputs are registered.
- Reset values: `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fail`=0, `lock_lost`=0, `retry_cnt`=0. State is PLL_RESET with `cnt`=RST_CYCLES-1.
- `pll_rst` is high for exactly RST_CYCLES clocks per attempt.
- Latency from a `locked_in` rise to `lock_s`: 2 cycles.
- `ready`/`sys_rst_n` rise STABLE_CYCLES+1 cycles after `lock_s` first goes high, provided the lock holds.
- Lock loss in RUN drops `ready`/`sys_rst_n` 3 cycles after the `locked_in` fall: 2 sync cycles plus 1 registered cycle. `pll_rst` rises on the same edge.
- `relock_req` takes effect on the next edge: `pll_rst`=1, `ready`=0.
- `retry_cnt` saturates at RETRY_MAX; no wrap-around.
- Asserting `rst_n` mid-sequence returns all outputs to their reset values asynchronously.

## Structure
- Package `pll_seq_pkg` holds the state enum `pll_seq_state_t` and the default parameter constants.
- Sub-module `sync_2ff` is the reusable 2-flop synchronizer. Its reset value is 0.
- The FSM and counter live in `pll_lock_sequencer`.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, RETRY_MAX=2.
1. Release reset, raise `locked_in` at cycle 10 → `pll_rst` high for cycles 0–3; `ready`=1 and `sys_rst_n`=1 at cycle 21; `retry_cnt`=0.
2. Hold `locked_in`=0 → two PLL_RESET pulses, then `fail`=1 with `retry_cnt`=2. Then pulse `relock_req` → `pll_rst`=1 the next cycle and `retry_cnt`=0.
3. In STABLE, glitch `locked_in` low for 1 cycle at count 5 → back to WAIT_LOCK, no PLL reset pulse. `ready` is delayed by a full 8-cycle window after the re-lock.
4. In RUN, drop `locked_in` → `ready`=0 after 3 cycles, `lock_lost`=1, a 4-cycle `pll_rst` pulse follows, and RUN is re-entered after lock returns.
5. Assert `relock_req` in the same cycle as WAIT_LOCK timeout → PLL_RESET taken, `retry_cnt`=0, `lock_lost` cleared.
6. Assert `rst_n` low mid-STABLE → immediate asynchronous `pll_rst`=1, `sys_rst_n`=0, all flags cleared.
